sram_fifo_ctrl: RTL and testbench

- Requester-side controller that drives an 8-entry x 236-bit 1R1W SRAM array wrapper through its R0/W0 ports.
- Presents a ready/valid enqueue/dequeue FIFO to the pipeline.
- Hides the array's 1-cycle synchronous read latency behind a 2-entry output skid buffer and an empty-queue bypass.
- Instanced beside the array macro in frontend/backend queues; the array clocks are tied to the same clock outside this block.

---
 rtl/sram_fifo_pkg.sv | 12 +
 rtl/sram_fifo_skid2.sv | 40 ++++
 rtl/sram_fifo_ctrl.sv | 92 +++++++++
 tb/tb_sram_fifo_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg: shared widths and skid slot type for the SRAM-backed FIFO controller
package sram_fifo_pkg;
    localparam int DATA_W = 236;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
    } skid_slot_t;
endpackage

// File: rtl/sram_fifo_skid2.sv
// sram_fifo_skid2: 2-entry in-order output buffer, slot 0 is the head
module sram_fifo_skid2
    import sram_fifo_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [1:0]        o_occ,
    output logic              o_head_valid,
    output logic [DATA_W-1:0] o_head_data
);
    skid_slot_t r_slot [2];
    skid_slot_t w_shift [2];
    skid_slot_t w_next [2];

    // pop moves slot 1 forward first, then a push lands in the first free slot
    always_comb begin
        w_shift[0] = i_pop ? r_slot[1] : r_slot[0];
        w_shift[1] = i_pop ? '0 : r_slot[1];
        w_next[0]  = (i_push && !w_shift[0].valid) ? {1'b1, i_push_data} : w_shift[0];
        w_next[1]  = (i_push && w_shift[0].valid) ? {1'b1, i_push_data} : w_shift[1];
    end

    // slot registers; reset drops only the valid bits
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_slot[0].valid <= 1'b0;
            r_slot[1].valid <= 1'b0;
        end else begin
            r_slot[0] <= w_next[0];
            r_slot[1] <= w_next[1];
        end
    end

    assign o_occ        = {1'b0, r_slot[0].valid} + {1'b0, r_slot[1].valid};
    assign o_head_valid = r_slot[0].valid;
    assign o_head_data  = r_slot[0].data;
endmodule

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: ready/valid FIFO over an 8x236 1R1W SRAM with skid buffer and empty bypass (perf counters under SRAM_FIFO_CTRL_PERF_EN)
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [DATA_W-1:0] enq_bits,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [DATA_W-1:0] deq_bits,
    output logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] mem_R0_addr,
    output logic              mem_R0_en,
    input  logic [DATA_W-1:0] mem_R0_data,
    output logic [ADDR_W-1:0] mem_W0_addr,
    output logic              mem_W0_en,
    output logic [DATA_W-1:0] mem_W0_data
`ifdef SRAM_FIFO_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_full_cycles,
    output logic [CNT_W-1:0]  perf_max_count
`endif
);
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_mem_cnt;
    logic              r_inflight;
    logic [1:0]        w_sk_occ;
    logic              w_enq_fire;
    logic              w_deq_fire;
    logic              w_bypass;
    logic              w_wr;
    logic              w_rd;

    assign enq_ready  = r_mem_cnt != CNT_W'(DEPTH);
    assign w_enq_fire = enq_valid && enq_ready;
    assign w_deq_fire = deq_valid && deq_ready;
    // bypass only when nothing older sits in the array or is on its way back
    assign w_bypass   = r_mem_cnt == '0 && !r_inflight && (w_sk_occ != 2'd2 || w_deq_fire);
    assign w_wr       = w_enq_fire && !w_bypass;
    // issue a read only if the skid will have room for the returning word
    assign w_rd       = r_mem_cnt != '0 &&
                        (3'(w_sk_occ) + 3'(r_inflight) < 3'd2 + 3'(w_deq_fire));

    assign mem_R0_en   = w_rd;
    assign mem_R0_addr = r_rd_ptr;
    assign mem_W0_en   = w_wr;
    assign mem_W0_addr = r_wr_ptr;
    assign mem_W0_data = enq_bits;
    assign count       = r_mem_cnt + CNT_W'(r_inflight) + CNT_W'(w_sk_occ);

    sram_fifo_skid2 u_skid (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_push      (r_inflight || (w_enq_fire && w_bypass)),
        .i_push_data (r_inflight ? mem_R0_data : enq_bits),
        .i_pop       (w_deq_fire),
        .o_occ       (w_sk_occ),
        .o_head_valid(deq_valid),
        .o_head_data (deq_bits)
    );

    // pointers, array occupancy and the read-in-flight flag
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + ADDR_W'(w_wr);
            r_rd_ptr   <= r_rd_ptr + ADDR_W'(w_rd);
            r_mem_cnt  <= r_mem_cnt + CNT_W'(w_wr) - CNT_W'(w_rd);
            r_inflight <= w_rd;
        end
    end

`ifdef SRAM_FIFO_CTRL_PERF_EN
    // saturating full-cycle counter and occupancy high-water mark
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            perf_full_cycles <= '0;
            perf_max_count   <= '0;
        end else begin
            if (!enq_ready && perf_full_cycles != '1) perf_full_cycles <= perf_full_cycles + 32'd1;
            if (count > perf_max_count) perf_max_count <= count;
        end
    end
`endif
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: directed and random stimulus, queue scoreboard checked at negedge
module tb_sram_fifo_ctrl;
    import sram_fifo_pkg::*;
    typedef logic [DATA_W-1:0] word_t;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              enq_valid = 1'b0;
    logic              deq_ready = 1'b0;
    word_t             enq_bits = '0;
    logic              enq_ready;
    logic              deq_valid;
    word_t             deq_bits;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] mem_R0_addr;
    logic              mem_R0_en;
    word_t             mem_R0_data;
    logic [ADDR_W-1:0] mem_W0_addr;
    logic              mem_W0_en;
    word_t             mem_W0_data;

    word_t arr [DEPTH];
    word_t model_q [$];
    int    errs = 0;
    int    checks = 0;

    always #5 clock = ~clock;

    sram_fifo_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enq_valid  (enq_valid),
        .enq_ready  (enq_ready),
        .enq_bits   (enq_bits),
        .deq_valid  (deq_valid),
        .deq_ready  (deq_ready),
        .deq_bits   (deq_bits),
        .count      (count),
        .mem_R0_addr(mem_R0_addr),
        .mem_R0_en  (mem_R0_en),
        .mem_R0_data(mem_R0_data),
        .mem_W0_addr(mem_W0_addr),
        .mem_W0_en  (mem_W0_en),
        .mem_W0_data(mem_W0_data)
    );

    // array macro stand-in: synchronous write, one-cycle registered read
    always @(posedge clock) begin
        if (mem_W0_en) arr[mem_W0_addr] <= mem_W0_data;
        if (mem_R0_en) mem_R0_data <= arr[mem_R0_addr];
    end

    task automatic chk(input string nm, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic word_t rnd();
        word_t w = '0;
        for (int k = 0; k < 8; k++) w = {w[DATA_W-33:0], $urandom};
        return w;
    endfunction

    task automatic drive(input logic v, input word_t d, input logic r);
        @(posedge clock);
        #1;
        enq_valid = v;
        enq_bits  = d;
        deq_ready = r;
    endtask

    // scoreboard: the model is an ideal FIFO of capacity DEPTH+2
    always @(negedge clock) begin
        if (!reset_n) begin
            model_q.delete();
        end else begin
            chk("count", word_t'(count), word_t'(model_q.size()));
            if (model_q.size() == 0) chk("deq_valid_empty", word_t'(deq_valid), word_t'(0));
            if (model_q.size() == DEPTH + 2) chk("enq_ready_full", word_t'(enq_ready), word_t'(0));
            if (model_q.size() < DEPTH) chk("enq_ready_room", word_t'(enq_ready), word_t'(1));
            if (mem_W0_en && mem_R0_en)
                chk("rw_addr_distinct", word_t'(mem_W0_addr != mem_R0_addr), word_t'(1));
            if (deq_valid && deq_ready && model_q.size() > 0)
                chk("deq_data", deq_bits, model_q.pop_front());
            if (enq_valid && enq_ready) model_q.push_back(enq_bits);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    initial begin
        int bias;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        // empty bypass
        drive(1'b1, word_t'('hA5), 1'b1);
        @(negedge clock);
        chk("bypass_no_write", word_t'(mem_W0_en), word_t'(0));
        drive(1'b0, '0, 1'b1);
        @(negedge clock);
        chk("bypass_valid", word_t'(deq_valid), word_t'(1));
        chk("bypass_data", deq_bits, word_t'('hA5));
        chk("bypass_no_write2", word_t'(mem_W0_en), word_t'(0));
        // fill to capacity
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, word_t'(i), 1'b0);
            @(negedge clock);
            chk("fill_ready", word_t'(enq_ready), word_t'(1));
            chk("fill_wen", word_t'(mem_W0_en), word_t'(i > 2));
            if (i > 2) chk("fill_waddr", word_t'(mem_W0_addr), word_t'(i - 3));
        end
        drive(1'b0, '0, 1'b0);
        @(negedge clock);
        chk("full_ready", word_t'(enq_ready), word_t'(0));
        chk("full_count", word_t'(count), word_t'(10));
        // drain with no bubbles
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, '0, 1'b1);
            @(negedge clock);
            chk("drain_valid", word_t'(deq_valid), word_t'(1));
            chk("drain_data", deq_bits, word_t'(i + 1));
            if (i >= 1) chk("drain_ready", word_t'(enq_ready), word_t'(1));
        end
        drive(1'b0, '0, 1'b0);
        @(negedge clock);
        chk("drained_count", word_t'(count), word_t'(0));
        // steady stream at occupancy 5
        for (int i = 0; i < 5; i++) drive(1'b1, word_t'(100 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, word_t'(200 + i), 1'b1);
            @(negedge clock);
            chk("steady_count", word_t'(count), word_t'(5));
            chk("steady_valid", word_t'(deq_valid), word_t'(1));
            chk("steady_data", deq_bits, word_t'(i < 5 ? 100 + i : 195 + i));
        end
        repeat (6) drive(1'b0, '0, 1'b1);
        // reset while a read is in flight
        for (int i = 0; i < 6; i++) drive(1'b1, word_t'(300 + i), 1'b0);
        drive(1'b1, word_t'(306), 1'b1);
        @(negedge clock);
        chk("midrst_read_issue", word_t'(mem_R0_en), word_t'(1));
        @(posedge clock);
        #1;
        reset_n   = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        @(negedge clock);
        chk("midrst_count_before", word_t'(count), word_t'(6));
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("rst_deq_valid", word_t'(deq_valid), word_t'(0));
        chk("rst_count", word_t'(count), word_t'(0));
        chk("rst_ren", word_t'(mem_R0_en), word_t'(0));
        chk("rst_enq_ready", word_t'(enq_ready), word_t'(1));
        drive(1'b1, word_t'('h3C), 1'b1);
        drive(1'b0, '0, 1'b1);
        @(negedge clock);
        chk("post_rst_valid", word_t'(deq_valid), word_t'(1));
        chk("post_rst_data", deq_bits, word_t'('h3C));
        // random traffic with shifting consumer pressure and rare resets
        for (int n = 0; n < 600; n++) begin
            bias = (n / 100) % 3 == 0 ? 20 : ((n / 100) % 3 == 1 ? 90 : 50);
            drive($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 99) < bias);
            reset_n = $urandom_range(0, 199) != 0;
        end
        drive(1'b0, '0, 1'b1);
        reset_n = 1'b1;
        repeat (12) drive(1'b0, '0, 1'b1);
        @(negedge clock);
        chk("final_empty", word_t'(count), word_t'(0));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
